snake_head_ctl: RTL and testbench

- Generates the snake-head position (xpos, ypos) consumed by the rectangle/sprite drawing stage in the VGA pipeline.
- Updates position only on the frame boundary, at the rising edge of vblnk, so the drawing stage never sees a position change mid-frame.
- Applies direction from four push-buttons, moves one grid step every FRAMES_PER_MOVE frames, and wraps around screen edges.
- Supports start and pause control.

---
 rtl/snake_head_ctl.sv | 153 +++++++++++++++
 tb/tb_snake_head_ctl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_head_ctl.sv
// Snake-head position controller: turns button requests into a committed direction
// and steps the head one grid cell every FRAMES_PER_MOVE frames, wrapping at screen edges.
module snake_head_ctl #(
    parameter int STEP            = 16,
    parameter int FRAMES_PER_MOVE = 8,
    parameter int X_MAX           = 976,
    parameter int Y_MAX           = 704,
    parameter int X_INIT          = 480,
    parameter int Y_INIT          = 352
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        start,
    input  logic        pause,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [1:0]  dir,
    output logic        move_tick,
    output logic        running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [1:0]  DIR_RIGHT = 2'd0;
    localparam logic [1:0]  DIR_DOWN  = 2'd1;
    localparam logic [1:0]  DIR_LEFT  = 2'd2;
    localparam logic [1:0]  DIR_UP    = 2'd3;

    localparam logic [11:0] STEP_W    = 12'(STEP);
    localparam logic [11:0] X_MAX_W   = 12'(X_MAX);
    localparam logic [11:0] Y_MAX_W   = 12'(Y_MAX);
    localparam logic [11:0] X_INIT_W  = 12'(X_INIT);
    localparam logic [11:0] Y_INIT_W  = 12'(Y_INIT);
    localparam logic [7:0]  CNT_LAST  = 8'(FRAMES_PER_MOVE - 1);

    state_t      state;
    logic [3:0]  btn_s1;
    logic [3:0]  btn_s2;
    logic        vblnk_q;
    logic        start_q;
    logic [7:0]  frame_cnt;
    logic [1:0]  pend_dir;

    logic        frame_tick;
    logic        start_rise;
    logic        move_now;
    logic        req_valid;
    logic [1:0]  req_dir;
    logic [1:0]  dir_eff;
    logic [11:0] next_x;
    logic [11:0] next_y;

    assign frame_tick = vblnk & ~vblnk_q;
    assign start_rise = start & ~start_q;
    assign move_now   = (state == RUN) && !start_rise && !pause && frame_tick
                        && (frame_cnt == CNT_LAST);

    // Reversal is judged against the direction that will be committed after this
    // edge, so a request arriving on the move cycle cannot sneak in a 180-degree turn.
    assign dir_eff    = move_now ? pend_dir : dir;

    always_comb begin
        req_valid = |btn_s2;
        req_dir   = DIR_RIGHT;
        if (btn_s2[3])      req_dir = DIR_UP;
        else if (btn_s2[2]) req_dir = DIR_DOWN;
        else if (btn_s2[1]) req_dir = DIR_LEFT;
    end

    always_comb begin
        next_x = xpos;
        next_y = ypos;
        case (pend_dir)
            DIR_RIGHT: next_x = (xpos == X_MAX_W) ? 12'd0   : xpos + STEP_W;
            DIR_LEFT:  next_x = (xpos == 12'd0)   ? X_MAX_W : xpos - STEP_W;
            DIR_DOWN:  next_y = (ypos == Y_MAX_W) ? 12'd0   : ypos + STEP_W;
            default:   next_y = (ypos == 12'd0)   ? Y_MAX_W : ypos - STEP_W;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; later assignments in the block intentionally override earlier ones.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            btn_s1    <= 4'd0;
            btn_s2    <= 4'd0;
            vblnk_q   <= 1'b0;
            start_q   <= 1'b0;
            frame_cnt <= 8'd0;
            pend_dir  <= DIR_RIGHT;
            dir       <= DIR_RIGHT;
            xpos      <= X_INIT_W;
            ypos      <= Y_INIT_W;
            move_tick <= 1'b0;
            running   <= 1'b0;
        end else begin
            btn_s1    <= {btn_up, btn_down, btn_left, btn_right};
            btn_s2    <= btn_s1;
            vblnk_q   <= vblnk;
            start_q   <= start;
            move_tick <= 1'b0;
            running   <= (state == RUN);

            if (req_valid && (req_dir != (dir_eff ^ 2'b10)))
                pend_dir <= req_dir;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        frame_cnt <= 8'd0;
                    end
                end
                RUN, PAUSE: begin
                    if (start_rise) begin
                        state     <= RUN;
                        frame_cnt <= 8'd0;
                        pend_dir  <= DIR_RIGHT;
                        dir       <= DIR_RIGHT;
                        xpos      <= X_INIT_W;
                        ypos      <= Y_INIT_W;
                    end else if (state == PAUSE) begin
                        if (!pause) state <= RUN;
                    end else if (pause) begin
                        state <= PAUSE;
                    end else if (frame_tick) begin
                        if (move_now) begin
                            frame_cnt <= 8'd0;
                            dir       <= pend_dir;
                            xpos      <= next_x;
                            ypos      <= next_y;
                            move_tick <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_head_ctl.sv
// Directed bench for snake_head_ctl: movement, wrap, reversal blocking, pause,
// restart, asynchronous reset and position stability outside the frame boundary.
module tb_snake_head_ctl;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [1:0]  dir;
    logic        move_tick;
    logic        running;

    int n_checks = 0;
    int n_fail   = 0;
    int mt_cnt   = 0;
    int mt_ref;
    bit mon_en   = 1'b0;
    logic [11:0] prev_x = 12'd0;

    snake_head_ctl dut (
        .pclk      (pclk),
        .rst       (rst),
        .vblnk     (vblnk),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .start     (start),
        .pause     (pause),
        .xpos      (xpos),
        .ypos      (ypos),
        .dir       (dir),
        .move_tick (move_tick),
        .running   (running)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            vblnk = 1'b1;
            cyc(3);
            vblnk = 1'b0;
            cyc(5);
        end
    endtask

    task automatic moves(input int n);
        frames(n * 8);
    endtask

    // Sampled 2 ns after each rising edge: counts move pulses and, when enabled,
    // requires xpos to hold across any edge where vblnk was low.
    always @(posedge pclk) begin
        #2;
        if (move_tick) mt_cnt++;
        if (mon_en) begin
            if (!vblnk) check("x_stable", xpos, prev_x);
            if (move_tick) check("tick_in_vblnk", vblnk, 1);
        end
        prev_x = xpos;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(2);
        check("rst_x", xpos, 480);
        check("rst_y", ypos, 352);
        check("rst_dir", dir, 0);
        check("rst_running", running, 0);
        check("rst_tick", move_tick, 0);
        rst = 1'b1;
        cyc(2);

        // Start; eight frames give exactly one move to the right
        start = 1'b1;
        cyc(2);
        check("start_running", running, 1);
        mt_ref = mt_cnt;
        frames(7);
        check("hold7_x", xpos, 480);
        check("hold7_ticks", mt_cnt - mt_ref, 0);
        frames(1);
        check("move1_x", xpos, 496);
        check("move1_y", ypos, 352);
        check("move1_dir", dir, 0);
        check("move1_ticks", mt_cnt - mt_ref, 1);

        // Left while moving right is a reversal and is ignored
        btn_left = 1'b1;
        cyc(4);
        moves(1);
        check("rev_dir", dir, 0);
        check("rev_x", xpos, 512);
        moves(29);
        check("xmax_x", xpos, 976);
        btn_left = 1'b0;
        moves(1);
        check("xwrap_x", xpos, 0);

        // Up and left together: up has priority
        btn_up = 1'b1;
        btn_left = 1'b1;
        cyc(4);
        moves(1);
        check("up_dir", dir, 3);
        check("up_y", ypos, 336);
        check("up_x", xpos, 0);
        btn_up = 1'b0;
        btn_left = 1'b0;
        cyc(4);
        moves(21);
        check("ymin_y", ypos, 0);
        moves(1);
        check("ywrap_y", ypos, 704);
        check("ywrap_dir", dir, 3);

        // Pause with the frame counter at 5
        frames(5);
        pause = 1'b1;
        cyc(2);
        check("pause_running", running, 0);
        mt_ref = mt_cnt;
        frames(20);
        check("pause_x", xpos, 0);
        check("pause_y", ypos, 704);
        check("pause_dir", dir, 3);
        check("pause_ticks", mt_cnt - mt_ref, 0);
        pause = 1'b0;
        cyc(2);
        check("resume_running", running, 1);
        frames(2);
        check("resume2_y", ypos, 704);
        frames(1);
        check("resume3_y", ypos, 688);

        // Restart on start rising edge clears position, direction and pending direction
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(1);
        check("restart_x", xpos, 480);
        check("restart_y", ypos, 352);
        check("restart_dir", dir, 0);
        moves(1);
        check("restart_move_x", xpos, 496);
        check("restart_move_y", ypos, 352);

        // Asynchronous reset mid-frame, away from any clock edge
        #1;
        rst = 1'b0;
        start = 1'b0;
        #1;
        check("arst_x", xpos, 480);
        check("arst_y", ypos, 352);
        check("arst_dir", dir, 0);
        check("arst_running", running, 0);
        @(negedge pclk);
        rst = 1'b1;
        frames(10);
        check("idle_x", xpos, 480);
        check("idle_running", running, 0);
        start = 1'b1;
        cyc(2);
        moves(1);
        check("after_arst_x", xpos, 496);

        // Irregular vblnk pulses: position moves only at rising edges of vblnk
        mon_en = 1'b1;
        repeat (16) begin
            cyc($urandom_range(3, 20));
            vblnk = 1'b1;
            cyc($urandom_range(1, 3));
            vblnk = 1'b0;
        end
        cyc(3);
        mon_en = 1'b0;
        check("rand_x", xpos, 528);
        check("rand_y", ypos, 352);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
